// File: rtl/change_monitor.sv
// rtl/change_monitor.sv - logs timestamped value changes of a monitored signal into a drainable FIFO
module change_monitor #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         sig,
    input  logic                     mon_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W+WIDTH-1:0]    out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0]       ts;
    logic [WIDTH-1:0]      prev;
    logic                  first;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  ovf_q;
    logic [CNT_W-1:0]      drop_q;
    logic [TS_W+WIDTH-1:0] mem [DEPTH];

    logic event_hit;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        event_hit = mon_en && (first || (sig != prev));
        full      = (level_q == LW'(DEPTH));
        pop       = (level_q != '0) && out_ready;
        push      = event_hit && (!full || pop);
        drop      = event_hit && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts      <= '0;
            prev    <= '0;
            first   <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            ts    <= ts + 1'b1;
            first <= !mon_en;
            if (mon_en) begin
                prev <= sig;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
            // A drop in the same cycle as a clear restarts the count at one.
            if (drop) begin
                ovf_q <= 1'b1;
                if (clr_ovf) begin
                    drop_q <= CNT_W'(1);
                end else if (drop_q != '1) begin
                    drop_q <= drop_q + 1'b1;
                end
            end else if (clr_ovf) begin
                ovf_q  <= 1'b0;
                drop_q <= '0;
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ts, sig};
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = mem[rd_ptr];
    assign level     = level_q;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_q;
endmodule

// File: doc/change_monitor.md
Name: change_monitor

Overview:
Synthesizable hardware successor to the simulation-only value monitor. It watches a WIDTH-bit signal and, while monitoring is enabled, logs each value change with a cycle timestamp into a DEPTH-entry FIFO. It also logs one entry on every monitor re-enable. A downstream consumer drains the FIFO over a valid/ready interface. It sits beside debug/trace logic and is driven by the system clock.

Parameters:
WIDTH, 8, width of monitored signal sig
DEPTH, 8, FIFO entries; power of 2, >=2
TS_W, 16, timestamp counter width
CNT_W, 8, drop counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
sig  input  WIDTH  monitored signal, sampled every rising edge
mon_en  input  1  1 = monitoring on (monitoron), 0 = off (monitoroff)
out_valid  output  1  FIFO non-empty; head entry presented
out_ready  input  1  consumer accepts head when out_valid=1
out_data  output  TS_W+WIDTH  head entry {ts, value}, ts in MSBs
level  output  $clog2(DEPTH)+1  current FIFO occupancy
ovf  output  1  sticky: at least one event dropped because FIFO was full
drop_cnt  output  CNT_W  dropped-event count, saturating at all-ones
clr_ovf  input  1  clears ovf and drop_cnt

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - ts, prev, pointers, level, ovf and drop_cnt go to 0.
  - first goes to 1.
  - out_valid=0. out_data is don't-care while out_valid=0.
  - Reset mid-operation discards all FIFO contents immediately.
- ts: free-running, +1 every cycle, wraps 2^TS_W-1 -> 0. mon_en does not affect it.
- Event detection (same cycle):
  - event = mon_en && (first || sig != prev).
  - Entry captured = {ts, sig}, using the current-cycle ts.
- prev: loads sig on every cycle with mon_en=1. Holds while mon_en=0.
- first:
  - Set on reset.
  - Set on any cycle with mon_en=0.
  - Cleared on any cycle with mon_en=1.
  - Effect: the first enabled cycle after reset or after any disable logs unconditionally, even if sig is unchanged.
- Changes of sig while mon_en=0 are never logged.
- Push/pop:
  - push = event && (!full || pop).
  - pop = out_valid && out_ready.
- Latency:
  - Event at edge t becomes visible as out_valid=1 / out_data after edge t (next cycle) when the FIFO was empty. No bypass.
  - out_data is driven combinationally from mem[rd_ptr].
- FIFO ordering: strict arrival order. Pointers wrap modulo DEPTH.
- level: +1 on push-only, -1 on pop-only, unchanged on push+pop or on neither.
- Full boundary:
  - Event while full with pop in the same cycle: accepted; level stays DEPTH.
  - Event while full without pop: dropped. ovf<=1; drop_cnt<=drop_cnt+1, saturating.
- Empty boundary: out_ready with out_valid=0 has no effect.
- clr_ovf=1: ovf<=0, drop_cnt<=0. If a drop occurs in the same cycle, the drop wins: ovf<=1, drop_cnt<=1.
- Consumer rule: the consumer must hold out_ready independent of out_valid. out_data is stable while out_valid=1 and no pop occurs.

Test Plan:
- Reset, mon_en=1, sig=0x00 held 5 cycles -> exactly one entry {ts=0,0x00}, out_valid rises the cycle after; level=1.
- sig sequence 0x00,0x01,0x01,0x10 on consecutive cycles with mon_en=1 -> entries {0,0x00},{1,0x01},{3,0x10}; drain with out_ready=1 returns them in that order; level returns to 0.
- mon_en=0 while sig goes 0x01->0x02->0x03, then mon_en=1 with sig=0x03 -> no entries during disable; one entry with value 0x03 on the re-enable cycle (mirrors monitoroff/monitoron).
- DEPTH=8, out_ready=0, 10 changes -> level=8, ovf=1, drop_cnt=2. Then pulse clr_ovf -> ovf=0, drop_cnt=0; FIFO contents intact.
- FIFO full, change and out_ready=1 in the same cycle -> event accepted, level stays 8, ovf stays 0. Drop coincident with clr_ovf -> ovf=1, drop_cnt=1.
- TS_W=4: first event at cycle 14, next at cycle 18 -> ts fields 14 and 2 (wrap). Assert rst_n=0 with level=5 -> next cycle level=0, out_valid=0, ovf=0.
